// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// atm_session_ctrl : ATM session sequencer (card, PIN lockout, menu, DB req)
// Revision: 1.0
// ---------------------------------------------------------------------------
module atm_session_ctrl #(
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int NUM_ACC     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic [3:0]  acc_num,
  input  logic        pin_valid,
  input  logic        auth_ok,
  input  logic        op_valid,
  input  logic [2:0]  operation,
  input  logic [15:0] amount,
  output logic        db_req,
  output logic [1:0]  db_op,
  output logic [3:0]  db_acc,
  output logic [15:0] db_amount,
  input  logic        db_ack,
  input  logic        db_ok,
  input  logic [15:0] db_balance,
  output logic [2:0]  state,
  output logic [15:0] balance,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code
);

  localparam int TW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TRW = $clog2(MAX_TRIES + 1);

  localparam logic [TW-1:0]  c_TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TRW-1:0] c_MAX_TRIES = TRW'(MAX_TRIES);
  localparam logic [4:0]     c_NUM_ACC   = 5'(NUM_ACC);

  localparam logic [2:0] c_E_BAD_PIN = 3'd1;
  localparam logic [2:0] c_E_LOCKED  = 3'd2;
  localparam logic [2:0] c_E_BAD_OP  = 3'd3;
  localparam logic [2:0] c_E_INSUF   = 3'd4;
  localparam logic [2:0] c_E_TIMEOUT = 3'd5;
  localparam logic [2:0] c_E_BAD_ACC = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AUTH    = 3'd1,
    S_MENU    = 3'd2,
    S_DB_WAIT = 3'd3,
    S_EJECT   = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_acc, w_acc_nxt;
  logic [15:0]    r_lock, w_lock_nxt;
  logic [TRW-1:0] r_tries, w_tries_nxt;
  logic [TW-1:0]  r_timer, w_timer_nxt;
  logic           r_db_req, w_req_nxt;
  logic [1:0]     r_db_op, w_op_nxt;
  logic [15:0]    r_db_amount, w_amt_nxt;
  logic [15:0]    r_balance, w_bal_nxt;
  logic           r_done, w_done_nxt;
  logic           r_error, w_err_nxt;
  logic [2:0]     r_err_code, w_code_nxt;

  logic           w_bad_acc;
  logic [TRW-1:0] w_tries_inc;
  logic           w_tmo;

  assign w_bad_acc   = ({1'b0, acc_num} >= c_NUM_ACC);
  assign w_tries_inc = r_tries + 1'b1;
  assign w_tmo       = (r_timer == c_TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_lock      <= '0;
      r_tries     <= '0;
      r_timer     <= '0;
      r_db_req    <= 1'b0;
      r_db_op     <= '0;
      r_db_amount <= '0;
      r_balance   <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_lock      <= w_lock_nxt;
      r_tries     <= w_tries_nxt;
      r_timer     <= w_timer_nxt;
      r_db_req    <= w_req_nxt;
      r_db_op     <= w_op_nxt;
      r_db_amount <= w_amt_nxt;
      r_balance   <= w_bal_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_err_nxt;
      r_err_code  <= w_code_nxt;
    end
  end

  // Priority inside AUTH/MENU: card removal, then strobe, then timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_lock_nxt  = r_lock;
    w_tries_nxt = r_tries;
    w_timer_nxt = r_timer;
    w_req_nxt   = r_db_req;
    w_op_nxt    = r_db_op;
    w_amt_nxt   = r_db_amount;
    w_bal_nxt   = r_balance;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (card_in) begin
          w_acc_nxt = acc_num;
          if (w_bad_acc) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = c_E_BAD_ACC;
            w_state_nxt = S_EJECT;
          end else if (r_lock[acc_num]) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = c_E_LOCKED;
            w_state_nxt = S_EJECT;
          end else begin
            w_tries_nxt = '0;
            w_timer_nxt = '0;
            w_state_nxt = S_AUTH;
          end
        end
      end
      S_AUTH: begin
        if (!card_in) begin
          w_bal_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (pin_valid) begin
          w_timer_nxt = '0;
          if (auth_ok) begin
            w_tries_nxt = '0;
            w_state_nxt = S_MENU;
          end else begin
            w_tries_nxt = w_tries_inc;
            w_err_nxt   = 1'b1;
            w_code_nxt  = c_E_BAD_PIN;
            if (w_tries_inc == c_MAX_TRIES) begin
              w_lock_nxt[r_acc] = 1'b1;
              w_code_nxt        = c_E_LOCKED;
              w_bal_nxt         = '0;
              w_state_nxt       = S_EJECT;
            end
          end
        end else if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_code_nxt  = c_E_TIMEOUT;
          w_bal_nxt   = '0;
          w_state_nxt = S_EJECT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_MENU: begin
        if (!card_in) begin
          w_bal_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (op_valid) begin
          w_timer_nxt = '0;
          case (operation)
            3'd1, 3'd2, 3'd3, 3'd4: begin
              if ((operation == 3'd2 || operation == 3'd3) && amount == 16'd0) begin
                w_err_nxt  = 1'b1;
                w_code_nxt = c_E_BAD_OP;
              end else begin
                w_op_nxt    = operation[1:0] - 2'd1;
                w_amt_nxt   = amount;
                w_req_nxt   = 1'b1;
                w_state_nxt = S_DB_WAIT;
              end
            end
            3'd5: begin
              w_bal_nxt   = '0;
              w_state_nxt = S_EJECT;
            end
            default: begin
              w_err_nxt  = 1'b1;
              w_code_nxt = c_E_BAD_OP;
            end
          endcase
        end else if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_code_nxt  = c_E_TIMEOUT;
          w_bal_nxt   = '0;
          w_state_nxt = S_EJECT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_DB_WAIT: begin
        if (db_ack) begin
          w_req_nxt   = 1'b0;
          w_timer_nxt = '0;
          if (db_ok) begin
            w_bal_nxt  = db_balance;
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt  = 1'b1;
            w_code_nxt = c_E_INSUF;
          end
          w_state_nxt = card_in ? S_MENU : S_IDLE;
        end
      end
      S_EJECT: begin
        w_bal_nxt = '0;
        if (!card_in) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign state     = r_state;
  assign db_req    = r_db_req;
  assign db_op     = r_db_op;
  assign db_acc    = r_acc;
  assign db_amount = r_db_amount;
  assign balance   = r_balance;
  assign done      = r_done;
  assign error     = r_error;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire
